// File: rtl/nbit_cc_shift_ring.sv
// Purpose : registered counter-clockwise (toward LSB) rotator, out[i] = in[(i + s) mod W_DATA].
// Latency : 1 cycle from input sample to bitline_out/bitline_valid.
// Backpressure: none; inputs are sampled on every rising clk edge.
//
// Ports:
//   clk           - single clock, rising edge
//   rst           - asynchronous, active-high reset (clears outputs immediately)
//   bitline_in    - W_DATA-bit data to rotate
//   shift_value   - W_SHIFT-bit unsigned rotate amount
//   bitline_out   - registered rotated data (0 when the shift is out of range)
//   bitline_valid - registered flag, bitline_out holds a legal rotation
//
// Optional feature: define NBIT_CC_SHIFT_RING_SHIFT_MODULO_EN to reduce
// shift_value >= W_DATA modulo W_DATA instead of flagging it invalid.
// Ports and latency are identical in both builds.

module nbit_cc_shift_ring #(
    parameter  int W_DATA  = 5,
    localparam int W_SHIFT = $clog2(W_DATA)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [W_DATA-1:0]  bitline_in,
    input  logic [W_SHIFT-1:0] shift_value,
    output logic [W_DATA-1:0]  bitline_out,
    output logic               bitline_valid
);

    logic [31:0]        w_shift_ext;
    logic [W_SHIFT-1:0] w_shift_eff;
    logic               w_in_range;

    assign w_shift_ext = 32'(shift_value);

`ifdef NBIT_CC_SHIFT_RING_SHIFT_MODULO_EN
    // Fold any amount back into 0..W_DATA-1; the result always fits W_SHIFT bits.
    assign w_shift_eff = W_SHIFT'(w_shift_ext % 32'(W_DATA));
    assign w_in_range  = 1'b1;
`else
    // Amounts >= W_DATA are only reachable for non-power-of-2 widths.
    assign w_shift_eff = shift_value;
    assign w_in_range  = (w_shift_ext < 32'(W_DATA));
`endif

    // Log2 barrel: stage k rotates toward the LSB by 2^k when shift bit k is set.
    // 2^k < W_DATA for every stage, so each stage is a plain slice of the
    // doubled vector.
    logic [W_DATA-1:0] w_stage [0:W_SHIFT];

    assign w_stage[0] = bitline_in;

    for (genvar k = 0; k < W_SHIFT; k++) begin : g_stage
        localparam int ROT = 1 << k;
        logic [2*W_DATA-1:0] w_dbl;
        assign w_dbl          = {w_stage[k], w_stage[k]};
        assign w_stage[k + 1] = w_shift_eff[k] ? w_dbl[ROT +: W_DATA] : w_stage[k];
    end

    logic [W_DATA-1:0] r_out;
    logic              r_valid;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_out   <= '0;
            r_valid <= 1'b0;
        end else begin
            r_out   <= w_in_range ? w_stage[W_SHIFT] : '0;
            r_valid <= w_in_range;
        end
    end

    assign bitline_out   = r_out;
    assign bitline_valid = r_valid;

endmodule

// File: tb/tb_nbit_cc_shift_ring.sv
module tb_nbit_cc_shift_ring;

`ifdef NBIT_CC_SHIFT_RING_SHIFT_MODULO_EN
    localparam bit MOD_EN = 1'b1;
`else
    localparam bit MOD_EN = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [4:0] in5 = '0;
    logic [2:0] s5  = '0;
    logic [4:0] out5;
    logic       v5;
    logic [7:0] in8 = '0;
    logic [2:0] s8  = '0;
    logic [7:0] out8;
    logic       v8;

    int n_pass  = 0;
    int n_total = 0;

    always #5 clk = ~clk;

    nbit_cc_shift_ring #(.W_DATA(5)) u_dut5 (
        .clk(clk), .rst(rst), .bitline_in(in5), .shift_value(s5),
        .bitline_out(out5), .bitline_valid(v5)
    );

    nbit_cc_shift_ring #(.W_DATA(8)) u_dut8 (
        .clk(clk), .rst(rst), .bitline_in(in8), .shift_value(s8),
        .bitline_out(out8), .bitline_valid(v8)
    );

    // Reference: {valid, data} for width w, built straight from the index rule.
    function automatic logic [8:0] model(input logic [7:0] d, input int w, input int s);
        logic [7:0] o;
        int         sh;
        o = '0;
        if (s >= w && !MOD_EN) return 9'd0;
        sh = s % w;
        for (int i = 0; i < w; i++) o[i] = d[(i + sh) % w];
        return {1'b1, o};
    endfunction

    task automatic test_reset();
        for (int c = 0; c < 4; c++) begin
            in5 = 5'($urandom); s5 = 3'($urandom);
            in8 = 8'($urandom); s8 = 3'($urandom);
            @(posedge clk); #1;
            n_total++;
            if (out5 !== 5'b0 || v5 !== 1'b0) $display("FAIL reset_hold5 got out=%b vld=%b want out=00000 vld=0", out5, v5);
            else n_pass++;
            n_total++;
            if (out8 !== 8'b0 || v8 !== 1'b0) $display("FAIL reset_hold8 got out=%b vld=%b want out=0 vld=0", out8, v8);
            else n_pass++;
        end
        @(negedge clk);
        rst = 1'b0;
        in5 = 5'b11010; s5 = 3'd1;
        @(posedge clk); #1;
        n_total++;
        if (out5 !== 5'b01101 || v5 !== 1'b1) $display("FAIL reset_release got out=%b vld=%b want out=01101 vld=1", out5, v5);
        else n_pass++;
    endtask

    task automatic test_sweep();
        logic [4:0] exp_tab [0:4];
        exp_tab[0] = 5'b11010; exp_tab[1] = 5'b01101; exp_tab[2] = 5'b10110;
        exp_tab[3] = 5'b01011; exp_tab[4] = 5'b10101;
        for (int s = 0; s < 5; s++) begin
            in5 = 5'b11010; s5 = 3'(s);
            @(posedge clk); #1;
            n_total++;
            if (out5 !== exp_tab[s] || v5 !== 1'b1)
                $display("FAIL sweep_s%0d got out=%b vld=%b want out=%b vld=1", s, out5, v5, exp_tab[s]);
            else n_pass++;
        end
    endtask

    task automatic test_out_of_range();
        logic [4:0] exp_tab [5:7];
        logic       exp_v;
        if (MOD_EN) begin
            exp_tab[5] = 5'b11010; exp_tab[6] = 5'b01101; exp_tab[7] = 5'b10110;
            exp_v = 1'b1;
        end else begin
            exp_tab[5] = 5'b0; exp_tab[6] = 5'b0; exp_tab[7] = 5'b0;
            exp_v = 1'b0;
        end
        for (int s = 5; s < 8; s++) begin
            in5 = 5'b11010; s5 = 3'(s);
            @(posedge clk); #1;
            n_total++;
            if (out5 !== exp_tab[s] || v5 !== exp_v)
                $display("FAIL out_of_range_s%0d got out=%b vld=%b want out=%b vld=%b", s, out5, v5, exp_tab[s], exp_v);
            else n_pass++;
        end
    endtask

    task automatic test_async_reset();
        in5 = 5'b11010; s5 = 3'd2;
        @(posedge clk); #1;
        n_total++;
        if (out5 !== 5'b10110 || v5 !== 1'b1) $display("FAIL async_pre got out=%b vld=%b want out=10110 vld=1", out5, v5);
        else n_pass++;
        #2 rst = 1'b1;
        #1;
        n_total++;
        if (out5 !== 5'b0 || v5 !== 1'b0) $display("FAIL async_clear got out=%b vld=%b want out=00000 vld=0", out5, v5);
        else n_pass++;
        in5 = 5'b11010; s5 = 3'd3;
        @(posedge clk); #1;
        n_total++;
        if (out5 !== 5'b0 || v5 !== 1'b0) $display("FAIL async_held got out=%b vld=%b want out=00000 vld=0", out5, v5);
        else n_pass++;
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk); #1;
        n_total++;
        if (out5 !== 5'b01011 || v5 !== 1'b1) $display("FAIL async_resume got out=%b vld=%b want out=01011 vld=1", out5, v5);
        else n_pass++;
    endtask

    task automatic test_pow2();
        in8 = 8'b10011010; s8 = 3'd3;
        @(posedge clk); #1;
        n_total++;
        if (out8 !== 8'b01010011 || v8 !== 1'b1) $display("FAIL pow2_s3 got out=%b vld=%b want out=01010011 vld=1", out8, v8);
        else n_pass++;
    endtask

    task automatic test_back_to_back();
        logic [8:0] e5, e8;
        for (int c = 0; c < 300; c++) begin
            in5 = 5'($urandom); s5 = 3'($urandom_range(0, 7));
            in8 = 8'($urandom); s8 = 3'($urandom_range(0, 7));
            e5 = model({3'b0, in5}, 5, int'(s5));
            e8 = model(in8, 8, int'(s8));
            @(posedge clk); #1;
            n_total++;
            if (out5 !== e5[4:0] || v5 !== e5[8])
                $display("FAIL b2b_w5 cyc%0d in=%b s=%0d got out=%b vld=%b want out=%b vld=%b", c, in5, s5, out5, v5, e5[4:0], e5[8]);
            else n_pass++;
            n_total++;
            if (out8 !== e8[7:0] || v8 !== e8[8])
                $display("FAIL b2b_w8 cyc%0d in=%b s=%0d got out=%b vld=%b want out=%b vld=%b", c, in8, s8, out8, v8, e8[7:0], e8[8]);
            else n_pass++;
        end
    endtask

    initial begin
        test_reset();
        test_sweep();
        test_out_of_range();
        test_async_reset();
        test_pow2();
        test_back_to_back();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
